shift_rows_stream: RTL

- Registered, parametrised AES/Rijndael ShiftRows and InvShiftRows stage with valid/ready streaming and a 2-entry output buffer.
- Sits between the SubBytes and MixColumns stages of the round datapath.
- Supports Rijndael block widths of 128, 192 and 256 bits, and a per-transaction forward/inverse mode.
- Replaces the combinational 128-bit forward-only permutation.

---
 rtl/aes_pkg.sv | 34 +++
 rtl/shift_rows_perm.sv | 32 +++
 rtl/shift_rows_stream.sv | 81 ++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES/Rijndael constants and byte-lane helpers for the round datapath.
// The state is column-major with byte 0 in the MSB lane (FIPS-197 ordering).
package aes_pkg;

  localparam int NB_128 = 4;
  localparam int NB_192 = 6;
  localparam int NB_256 = 8;

  typedef enum logic {
    MODE_FWD = 1'b0,
    MODE_INV = 1'b1
  } sr_mode_e;

  function automatic bit nb_is_legal(int nb);
    return (nb == NB_128) || (nb == NB_192) || (nb == NB_256);
  endfunction

  // Rijndael row offsets: 256-bit blocks use 1/3/4, the narrower blocks use 1/2/3.
  function automatic int row_shift(int nb, int r);
    if (r == 0) begin
      return 0;
    end
    if (nb == NB_256) begin
      return (r == 1) ? 1 : r + 1;
    end
    return r;
  endfunction

  // Lowest bit of state byte (r,c): byte k = 4c+r occupies [W-1-8k -: 8].
  function automatic int byte_lsb(int nb, int r, int c);
    return 32 * nb - 8 * (4 * c + r) - 8;
  endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation for NB = 4, 6 or 8.
// Pure wiring plus one 2:1 mux per byte; reused by the key-schedule/decrypt path.
module shift_rows_perm
  import aes_pkg::*;
#(
  parameter int NB = NB_128
) (
  input  logic              inverse,
  input  logic [32*NB-1:0]  din,
  output logic [32*NB-1:0]  dout
);

  if (!nb_is_legal(NB)) begin : g_bad_nb
    $error("shift_rows_perm: NB must be 4, 6 or 8");
  end

  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int SH      = row_shift(NB, r);
      localparam int FWD_SRC = (c + SH) % NB;
      // Adding NB before the modulo keeps the inverse source column non-negative.
      localparam int INV_SRC = (c + NB - SH) % NB;
      localparam int DST_LSB = byte_lsb(NB, r, c);
      localparam int FWD_LSB = byte_lsb(NB, r, FWD_SRC);
      localparam int INV_LSB = byte_lsb(NB, r, INV_SRC);

      assign dout[DST_LSB +: 8] = (inverse == MODE_INV) ? din[INV_LSB +: 8]
                                                        : din[FWD_LSB +: 8];
    end
  end

endmodule

// File: rtl/shift_rows_stream.sv
// Registered ShiftRows/InvShiftRows stage: permute on entry, then a 2-entry FIFO
// that gives full throughput with in_ready driven only from registered occupancy.
module shift_rows_stream
  import aes_pkg::*;
#(
  parameter  int NB = NB_128,
  localparam int W  = 32 * NB
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_inverse,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          out_inverse,
  output logic [1:0]    occupancy
);

  logic [W-1:0] w_perm;
  logic         w_push;
  logic         w_pop;

  logic [W-1:0] r_data [2];
  logic [1:0]   r_inv;
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_occ;

  shift_rows_perm #(
    .NB (NB)
  ) u_perm (
    .inverse (in_inverse),
    .din     (in_data),
    .dout    (w_perm)
  );

  // NOTE: in_ready looks only at r_occ, so there is no combinational path from out_ready.
  assign in_ready    = (r_occ != 2'd2);
  assign out_valid   = (r_occ != 2'd0);
  assign occupancy   = r_occ;
  assign out_data    = r_data[r_rd_ptr];
  assign out_inverse = r_inv[r_rd_ptr];

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: storage is reset too, so out_data is 0 and never X before the first write.
      r_data[0] <= '0;
      r_data[1] <= '0;
      r_inv     <= '0;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_occ     <= 2'd0;
    end else if (clear) begin
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_occ     <= 2'd0;
    end else begin
      if (w_push) begin
        r_data[r_wr_ptr] <= w_perm;
        r_inv[r_wr_ptr]  <= in_inverse;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule
